// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch target predictor.
// Entry fields are sized for the widest supported configuration; narrower instances zero-extend.
package bp_pkg;

    localparam int MAX_PC_WIDTH = 64;
    localparam int MAX_CTR_BITS = 8;

    typedef logic [MAX_PC_WIDTH-1:0] bp_addr_t;
    typedef logic [MAX_CTR_BITS-1:0] bp_ctr_t;

    typedef struct packed {
        logic     valid;
        bp_addr_t tag;
        bp_addr_t target;
        logic     is_jump;
        bp_ctr_t  ctr;
    } bp_entry_t;

    function automatic bp_ctr_t ctr_max(input int bits);
        return bp_ctr_t'((1 << bits) - 1);
    endfunction

    function automatic bp_ctr_t ctr_weak_t(input int bits);
        return bp_ctr_t'(1 << (bits - 1));
    endfunction

    function automatic bp_ctr_t ctr_weak_nt(input int bits);
        return bp_ctr_t'((1 << (bits - 1)) - 1);
    endfunction

    // Word-aligned index: pc[ib+1:2], returned zero-extended.
    function automatic bp_addr_t bp_index(input bp_addr_t pc, input int ib);
        bp_addr_t mask;
        mask = (bp_addr_t'(1) << ib) - bp_addr_t'(1);
        return (pc >> 2) & mask;
    endfunction

    function automatic bp_addr_t bp_tag(input bp_addr_t pc, input int ib);
        return pc >> (ib + 2);
    endfunction

endpackage

// File: rtl/bp_sat_ctr.sv
// Saturating up/down next-value function for a direction counter.
module bp_sat_ctr #(
    parameter int CTR_BITS = 2
) (
    input  logic [CTR_BITS-1:0] ctr,
    input  logic                up,
    output logic [CTR_BITS-1:0] ctr_next
);

    always_comb begin
        ctr_next = ctr;
        if (up) begin
            if (ctr != '1) ctr_next = ctr + CTR_BITS'(1);
        end else begin
            if (ctr != '0) ctr_next = ctr - CTR_BITS'(1);
        end
    end

endmodule

// File: rtl/branch_target_predictor.sv
// Direct-mapped BTB with per-entry direction counters: zero-latency fetch lookup,
// MEM-stage update with mispredict/redirect, and saturating resolution statistics.
module branch_target_predictor
    import bp_pkg::*;
#(
    parameter int PC_WIDTH   = 32,
    parameter int ENTRIES    = 16,
    parameter int CTR_BITS   = 2,
    parameter int STAT_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pred_en,
    input  logic                  clear,
    input  logic [PC_WIDTH-1:0]   if_pc,
    output logic                  pred_taken,
    output logic [PC_WIDTH-1:0]   pred_next_pc,
    input  logic                  upd_valid,
    input  logic [PC_WIDTH-1:0]   upd_pc,
    input  logic                  upd_is_branch,
    input  logic                  upd_is_jump,
    input  logic                  upd_taken,
    input  logic [PC_WIDTH-1:0]   upd_target,
    input  logic                  upd_pred_taken,
    input  logic [PC_WIDTH-1:0]   upd_pred_target,
    output logic                  mispredict,
    output logic [PC_WIDTH-1:0]   redirect_pc,
    output logic [STAT_WIDTH-1:0] stat_resolved,
    output logic [STAT_WIDTH-1:0] stat_mispredict
);

    localparam int      IB          = $clog2(ENTRIES);
    localparam bp_ctr_t CTR_WEAK_T  = ctr_weak_t(CTR_BITS);
    localparam bp_ctr_t CTR_WEAK_NT = ctr_weak_nt(CTR_BITS);
    localparam bp_entry_t RESET_ENTRY = '{valid: 1'b0, tag: '0, target: '0,
                                          is_jump: 1'b0, ctr: CTR_WEAK_NT};

    bp_entry_t table_q [ENTRIES];

    bp_addr_t      lk_pc;
    logic [IB-1:0] lk_idx;
    bp_entry_t     lk_entry;
    logic          lk_hit;

    assign lk_pc    = bp_addr_t'(if_pc);
    assign lk_idx   = IB'(bp_index(lk_pc, IB));
    assign lk_entry = table_q[lk_idx];
    assign lk_hit   = lk_entry.valid && (lk_entry.tag == bp_tag(lk_pc, IB));

    // Counter MSB set is the same as being at or above the weakly-taken value.
    assign pred_taken   = pred_en && lk_hit && (lk_entry.is_jump || (lk_entry.ctr >= CTR_WEAK_T));
    assign pred_next_pc = pred_taken ? PC_WIDTH'(lk_entry.target) : if_pc + PC_WIDTH'(4);

    bp_addr_t      up_pc;
    logic [IB-1:0] up_idx;
    logic          up_hit;
    logic          upd_ctrl;
    logic          ctr_step;
    logic [CTR_BITS-1:0] ctr_next;
    bp_entry_t     new_entry;

    assign up_pc    = bp_addr_t'(upd_pc);
    assign up_idx   = IB'(bp_index(up_pc, IB));
    assign up_hit   = table_q[up_idx].valid && (table_q[up_idx].tag == bp_tag(up_pc, IB));
    assign upd_ctrl = upd_is_branch || upd_is_jump;
    // Jump wins when both type flags are set, so the counter only moves for pure branches.
    assign ctr_step = upd_is_branch && !upd_is_jump;

    assign mispredict = upd_valid && (upd_ctrl
        ? ((upd_pred_taken != upd_taken) || (upd_taken && (upd_pred_target != upd_target)))
        : upd_pred_taken);
    assign redirect_pc = upd_taken ? upd_target : upd_pc + PC_WIDTH'(4);

    bp_sat_ctr #(.CTR_BITS(CTR_BITS)) u_sat_ctr (
        .ctr      (CTR_BITS'(table_q[up_idx].ctr)),
        .up       (upd_taken),
        .ctr_next (ctr_next)
    );

    assign new_entry = '{valid: 1'b1, tag: bp_tag(up_pc, IB), target: bp_addr_t'(upd_target),
                         is_jump: upd_is_jump, ctr: CTR_WEAK_T};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) table_q[i] <= RESET_ENTRY;
            stat_resolved   <= '0;
            stat_mispredict <= '0;
        end else begin
            if (clear) begin
                for (int i = 0; i < ENTRIES; i++) table_q[i].valid <= 1'b0;
            end else if (upd_valid) begin
                if (upd_ctrl) begin
                    if (up_hit) begin
                        if (ctr_step) table_q[up_idx].ctr <= bp_ctr_t'(ctr_next);
                        if (upd_taken) table_q[up_idx].target <= bp_addr_t'(upd_target);
                        table_q[up_idx].is_jump <= upd_is_jump;
                    end else if (upd_taken) begin
                        table_q[up_idx] <= new_entry;
                    end
                end else if (up_hit) begin
                    // A non-control instruction hit means a stale alias; drop it.
                    table_q[up_idx].valid <= 1'b0;
                end
            end
            if (upd_valid && upd_ctrl && (stat_resolved != '1))
                stat_resolved <= stat_resolved + STAT_WIDTH'(1);
            if (mispredict && (stat_mispredict != '1))
                stat_mispredict <= stat_mispredict + STAT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed bench for branch_target_predictor: a per-cycle reference model plus
// hand-computed expectations at the key points of each scenario.
module tb_branch_target_predictor;

    localparam int PCW = 32;
    localparam int NENT = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic           pred_en;
    logic           clear;
    logic [PCW-1:0] if_pc;
    logic           pred_taken;
    logic [PCW-1:0] pred_next_pc;
    logic           upd_valid;
    logic [PCW-1:0] upd_pc;
    logic           upd_is_branch;
    logic           upd_is_jump;
    logic           upd_taken;
    logic [PCW-1:0] upd_target;
    logic           upd_pred_taken;
    logic [PCW-1:0] upd_pred_target;
    logic           mispredict;
    logic [PCW-1:0] redirect_pc;
    logic [31:0]    stat_resolved;
    logic [31:0]    stat_mispredict;

    int n_vec = 0;
    int n_err = 0;

    branch_target_predictor #(
        .PC_WIDTH(PCW), .ENTRIES(NENT), .CTR_BITS(2), .STAT_WIDTH(32)
    ) dut (
        .clk(clk), .rst(rst), .pred_en(pred_en), .clear(clear), .if_pc(if_pc),
        .pred_taken(pred_taken), .pred_next_pc(pred_next_pc),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_branch(upd_is_branch),
        .upd_is_jump(upd_is_jump), .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
        .mispredict(mispredict), .redirect_pc(redirect_pc),
        .stat_resolved(stat_resolved), .stat_mispredict(stat_mispredict)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain arrays indexed by word address modulo table size.
    bit          m_valid [NENT];
    int unsigned m_tag   [NENT];
    int unsigned m_tgt   [NENT];
    bit          m_jump  [NENT];
    int          m_ctr   [NENT];
    int unsigned m_res;
    int unsigned m_mis;

    function automatic int m_idx(input int unsigned pc);
        return (pc / 4) % NENT;
    endfunction

    function automatic int unsigned m_tg(input int unsigned pc);
        return pc / (4 * NENT);
    endfunction

    function automatic bit m_hit(input int unsigned pc);
        return m_valid[m_idx(pc)] && (m_tag[m_idx(pc)] == m_tg(pc));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NENT; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_jump[i] = 0; m_ctr[i] = 1;
        end
        m_res = 0;
        m_mis = 0;
    endtask

    bit          e_tk;
    int unsigned e_nx;
    bit          e_mis;
    int unsigned e_red;

    task automatic model_outputs();
        int i;
        i = m_idx(if_pc);
        e_tk = pred_en && m_hit(if_pc) && (m_jump[i] || m_ctr[i] >= 2);
        e_nx = e_tk ? m_tgt[i] : if_pc + 4;
        if (!upd_valid) e_mis = 0;
        else if (upd_is_branch || upd_is_jump)
            e_mis = (upd_pred_taken != upd_taken) || (upd_taken && upd_pred_target != upd_target);
        else e_mis = upd_pred_taken;
        e_red = upd_taken ? upd_target : upd_pc + 4;
    endtask

    task automatic model_update();
        int  i;
        bit  h;
        i = m_idx(upd_pc);
        h = m_hit(upd_pc);
        if (upd_valid && (upd_is_branch || upd_is_jump) && m_res != 32'hffff_ffff) m_res++;
        if (e_mis && m_mis != 32'hffff_ffff) m_mis++;
        if (clear) begin
            for (int k = 0; k < NENT; k++) m_valid[k] = 0;
        end else if (upd_valid) begin
            if (upd_is_branch || upd_is_jump) begin
                if (h) begin
                    if (!upd_is_jump) m_ctr[i] = upd_taken ? (m_ctr[i] == 3 ? 3 : m_ctr[i] + 1)
                                                           : (m_ctr[i] == 0 ? 0 : m_ctr[i] - 1);
                    if (upd_taken) m_tgt[i] = upd_target;
                    m_jump[i] = upd_is_jump;
                end else if (upd_taken) begin
                    m_valid[i] = 1; m_tag[i] = m_tg(upd_pc); m_tgt[i] = upd_target;
                    m_jump[i] = upd_is_jump; m_ctr[i] = 2;
                end
            end else if (h) begin
                m_valid[i] = 0;
            end
        end
    endtask

    // Inputs are stable from posedge+1 to the next posedge, so compare then advance the model here.
    always @(negedge clk) begin
        if (rst) model_reset();
        model_outputs();
        check("cyc_pred_taken", pred_taken, e_tk);
        check("cyc_pred_next_pc", pred_next_pc, e_nx);
        check("cyc_mispredict", mispredict, e_mis);
        check("cyc_redirect_pc", redirect_pc, e_red);
        check("cyc_stat_resolved", stat_resolved, m_res);
        check("cyc_stat_mispredict", stat_mispredict, m_mis);
        if (!rst) model_update();
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_upd(input logic br, input logic jmp, input logic tk,
                           input logic [31:0] pc, input logic [31:0] tgt,
                           input logic ptk, input logic [31:0] ptgt);
        upd_valid = 1'b1; upd_is_branch = br; upd_is_jump = jmp; upd_taken = tk;
        upd_pc = pc; upd_target = tgt; upd_pred_taken = ptk; upd_pred_target = ptgt;
    endtask

    task automatic idle_upd();
        upd_valid = 1'b0; upd_is_branch = 1'b0; upd_is_jump = 1'b0; upd_taken = 1'b0;
        upd_pc = '0; upd_target = '0; upd_pred_taken = 1'b0; upd_pred_target = '0;
    endtask

    task automatic look(input logic [31:0] pc, input logic tk, input logic [31:0] nx);
        if_pc = pc;
        #1;
        check("lk_pred_taken", pred_taken, tk);
        check("lk_pred_next_pc", pred_next_pc, nx);
    endtask

    initial begin
        model_reset();
        rst = 1'b1; pred_en = 1'b1; clear = 1'b0; if_pc = 32'h100;
        idle_upd();
        #2;
        check("rst_pred_taken", pred_taken, 0);
        check("rst_next_pc", pred_next_pc, 32'h104);
        check("rst_stat_resolved", stat_resolved, 0);
        check("rst_stat_mispredict", stat_mispredict, 0);
        tick(); tick();
        rst = 1'b0;

        // Allocate a taken branch
        set_upd(1, 0, 1, 32'h100, 32'h80, 0, 32'h104);
        #1;
        check("alloc_mispredict", mispredict, 1);
        check("alloc_redirect", redirect_pc, 32'h80);
        tick(); idle_upd();
        look(32'h100, 1, 32'h80);
        check("alloc_stat_mis", stat_mispredict, 1);
        check("alloc_stat_res", stat_resolved, 1);

        // Counter walk down to saturation at 0
        tick();
        set_upd(1, 0, 0, 32'h100, 32'h80, 1, 32'h80);
        #1;
        check("walk_mispredict", mispredict, 1);
        check("walk_redirect", redirect_pc, 32'h104);
        tick(); set_upd(1, 0, 0, 32'h100, 32'h80, 0, 32'h104);
        #1;
        check("walk2_mispredict", mispredict, 0);
        tick(); set_upd(1, 0, 0, 32'h100, 32'h80, 0, 32'h104);
        tick(); idle_upd();
        look(32'h100, 0, 32'h104);

        // Alias at the same index replaces the entry
        tick(); set_upd(1, 0, 1, 32'h140, 32'h200, 0, 32'h144);
        tick(); idle_upd();
        look(32'h100, 0, 32'h104);
        look(32'h140, 1, 32'h200);

        // Saturate up at 3, then walk down
        tick(); set_upd(1, 0, 1, 32'h140, 32'h200, 1, 32'h200);
        tick(); set_upd(1, 0, 1, 32'h140, 32'h200, 1, 32'h200);
        tick(); set_upd(1, 0, 0, 32'h140, 32'h200, 1, 32'h200);
        tick(); idle_upd();
        look(32'h140, 1, 32'h200);
        tick(); set_upd(1, 0, 0, 32'h140, 32'h200, 1, 32'h200);
        tick(); idle_upd();
        look(32'h140, 0, 32'h144);

        // Jump entry and pred_en gating
        tick(); set_upd(0, 1, 1, 32'h10C, 32'h400, 0, 32'h110);
        tick(); idle_upd();
        look(32'h10C, 1, 32'h400);
        tick(); pred_en = 1'b0;
        look(32'h10C, 0, 32'h110);
        tick(); pred_en = 1'b1;
        look(32'h10C, 1, 32'h400);

        // Both type flags behave as a jump; new target taken
        tick(); set_upd(1, 1, 1, 32'h10C, 32'h500, 1, 32'h400);
        tick(); idle_upd();
        look(32'h10C, 1, 32'h500);

        // Non-branch hit invalidates a stale alias
        tick(); set_upd(0, 0, 0, 32'h10C, 32'h0, 1, 32'h500);
        #1;
        check("nonbr_mispredict", mispredict, 1);
        check("nonbr_redirect", redirect_pc, 32'h110);
        tick(); idle_upd();
        look(32'h10C, 0, 32'h110);

        // Same-cycle lookup and update: pre-update contents are seen
        tick(); if_pc = 32'h180; set_upd(1, 0, 1, 32'h180, 32'h600, 0, 32'h184);
        #1;
        check("rbw_pred_taken", pred_taken, 0);
        check("rbw_next_pc", pred_next_pc, 32'h184);
        tick(); idle_upd();
        look(32'h180, 1, 32'h600);

        // Clear wins over a simultaneous allocation; statistics still count
        tick(); set_upd(1, 0, 1, 32'h120, 32'h300, 0, 32'h124); clear = 1'b1;
        tick(); clear = 1'b0; idle_upd();
        look(32'h180, 0, 32'h184);
        look(32'h120, 0, 32'h124);
        check("clear_stat_res", stat_resolved, 13);
        check("clear_stat_mis", stat_mispredict, 10);

        // Asynchronous reset during an update
        tick(); set_upd(1, 0, 1, 32'h140, 32'h80, 0, 32'h144); if_pc = 32'h140;
        #1; rst = 1'b1;
        #1;
        check("arst_stat_res", stat_resolved, 0);
        check("arst_stat_mis", stat_mispredict, 0);
        check("arst_next_pc", pred_next_pc, 32'h144);
        tick(); rst = 1'b0; idle_upd();
        tick();
        look(32'h140, 0, 32'h144);
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
